prod_arbiter: RTL and testbench
===============================

# prod_arbiter

Round-robin arbiter that shares the buffer write port (`data_1`/`data_1_en` into the wrapper) between the Fibonacci and Timer producers. It replaces the single-owner producer sequencing in the top level: both producers may be requested at once and are granted alternately in bursts, with full-stall, stop and drain handling. All inputs are synchronous to `clk`; the top level resynchronises producer outputs before they enter this block.

## Interface
- `DW`, 16: producer and buffer data width.
- `BURST`, 8: words accepted per grant before the grant rotates (≥1); counter width is `$clog2(BURST)`, minimum 1.

- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset (asserts immediately, releases on `clk`).
- `start_f`  in  1: one-cycle pulse (edge-detected), request Fibonacci production.
- `start_t`  in  1: one-cycle pulse, request Timer production.
- `stop`  in  1: one-cycle pulse, cancel all requests and drain.
- `buffer_full`  in  1: buffer cannot accept a write this cycle.
- `buffer_empty`  in  1: buffer holds no words.
- `data_valid_2`  in  1: consumer side still presenting a word.
- `f_valid`, `t_valid`  in  1: producer word valid.
- `f_out`, `t_out`  in  DW: producer data.
- `f_en`, `t_en`  out  1: producer enable (combinational).
- `data_1`  out  DW: registered buffer write data.
- `data_1_en`  out  1: registered buffer write strobe.
- `modulo`  out  2: 0 none, 1 Fibonacci owns port, 2 Timer owns port.
- `state_led`  out  4: one-hot state, bit0 IDLE … bit3 DRAIN.

## Operation
- Registers: `state`, `owner` (0=F, 1=T), `req_f`, `req_t`, `burst_cnt`, `data_1`, `data_1_en`.
- `start_f`/`start_t` set `req_f`/`req_t` in IDLE, COMM and WAIT_FULL; they are ignored in DRAIN. `stop` clears both requests and has priority over any start in the same cycle.
- States:
  - IDLE (0). On any request go to COMM. Owner = F if `req_f` (or `start_f` this cycle), else T. If both are set, F wins.
  - COMM (1). Owner enable = 1 when `!buffer_full`. `buffer_full` → WAIT_FULL. `stop` → DRAIN.
  - WAIT_FULL (2). Both enables low. `!buffer_full` → COMM with `burst_cnt` held. `stop` → DRAIN. If both conditions hold, `stop` wins.
  - DRAIN (3). Both enables low. `buffer_empty && !data_valid_2 && !data_1_en` → IDLE.
- `f_en = (state==COMM) && owner==F && !buffer_full && !stop`; `t_en` is the same with owner T.
- A word is accepted when `x_en && x_valid`. On accept: `data_1 <= x_out`, `data_1_en <= 1`. Otherwise `data_1_en <= 0` and `data_1` holds.
- Burst: each accept increments `burst_cnt`. An accept at `BURST-1` wraps the count to 0; if the other request is set, `owner` toggles on the same edge, otherwise the owner is kept.
- The other producer's start during COMM waits for the burst boundary; it is never granted mid-burst.
- `modulo` = owner+1 in COMM/WAIT_FULL, else 0.

## Timing
- Reset values: `state` IDLE, `owner` F, requests 0, `burst_cnt` 0, `data_1` 0, `data_1_en` 0, `f_en`/`t_en` 0, `modulo` 0, `state_led` 4'b0001.
- Start pulse at cycle n → COMM at n+1, enable high at n+1 (if not full).
- Accept at n → `data_1_en` high at n+1 (latency 1), one strobe per accept, back-to-back capable.
- `stop` at n: enables low at n (combinational). A word accepted at n-1 is still written at n. DRAIN at n+1.
- `buffer_full` rise at n: enables low at n, WAIT_FULL at n+1.
- Reset mid-burst: all state cleared immediately, in-flight strobe dropped.

## Structure
- Shared package `prod_pkg`: state encoding (`S_IDLE..S_DRAIN`), owner and `modulo` constants, default `DW`.
- No sub-module. `edge_detector` instances stay in the top level, which now instantiates `prod_arbiter` instead of its inline producer FSM.

## Test plan
- Reset then `start_f`, `f_valid`=1 with `f_out` 1,1,2,3 → `data_1_en` pulses from cycle 2 with `data_1`=1,1,2,3, `modulo`=1.
- `start_f` and `start_t` in the same cycle, BURST=4, both valid → 4 F words, 4 T words, 4 F words…, no gap at the switch, `modulo` alternates 1/2.
- `buffer_full` held 5 cycles after 2 of 4 burst words → WAIT_FULL for 5 cycles, no strobes, then 2 more F words before T.
- `stop` with `start_t` same cycle during COMM → DRAIN, T not requested. `buffer_empty`=1 and `data_valid_2`=0 → IDLE next cycle, `state_led`=0001.
- DRAIN with `buffer_empty`=0 for 10 cycles and starts pulsed → stays in DRAIN, enables 0, starts ignored.
- `rst` asserted low mid-burst → all outputs at reset values asynchronously. After release, `start_t` → `owner` T, `modulo`=2.

Source files
------------

// File: rtl/prod_pkg.sv
// Shared definitions for the producer arbiter: state encoding, owner and
// modulo codes, and the default data width.
package prod_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMM      = 2'd1,
    S_WAIT_FULL = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_T = 1'b1;

  localparam logic [1:0] MOD_NONE = 2'd0;
  localparam logic [1:0] MOD_F    = 2'd1;
  localparam logic [1:0] MOD_T    = 2'd2;

endpackage

// File: rtl/prod_arbiter.sv
// Round-robin arbiter sharing the buffer write port between the Fibonacci
// and Timer producers, with burst rotation, full stall, stop and drain.
module prod_arbiter
  import prod_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_f,
  input  logic          start_t,
  input  logic          stop,
  input  logic          buffer_full,
  input  logic          buffer_empty,
  input  logic          data_valid_2,
  input  logic          f_valid,
  input  logic          t_valid,
  input  logic [DW-1:0] f_out,
  input  logic [DW-1:0] t_out,
  output logic          f_en,
  output logic          t_en,
  output logic [DW-1:0] data_1,
  output logic          data_1_en,
  output logic [1:0]    modulo,
  output logic [3:0]    state_led
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  state_t        state, state_next;
  logic          owner, owner_next;
  logic          req_f, req_t;
  logic [CW-1:0] burst_cnt;
  logic          accept;
  logic          burst_end;
  logic          other_req;
  logic [DW-1:0] accept_data;

  // Enables drop combinationally on full or stop so no word slips through.
  assign f_en = (state == S_COMM) && (owner == OWN_F) && !buffer_full && !stop;
  assign t_en = (state == S_COMM) && (owner == OWN_T) && !buffer_full && !stop;

  assign accept      = (f_en && f_valid) || (t_en && t_valid);
  assign accept_data = (owner == OWN_T) ? t_out : f_out;
  assign burst_end   = accept && (burst_cnt == LAST);
  assign other_req   = (owner == OWN_F) ? req_t : req_f;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    owner_next = owner;
    modulo     = MOD_NONE;
    state_led  = 4'b0001;
    case (state)
      S_IDLE: begin
        if (!stop && (req_f || req_t || start_f || start_t)) begin
          state_next = S_COMM;
          owner_next = (req_f || start_f) ? OWN_F : OWN_T;
        end
      end
      S_COMM: begin
        if (stop)             state_next = S_DRAIN;
        else if (buffer_full) state_next = S_WAIT_FULL;
        if (burst_end && other_req) owner_next = ~owner;
      end
      S_WAIT_FULL: begin
        if (stop)              state_next = S_DRAIN;
        else if (!buffer_full) state_next = S_COMM;
      end
      S_DRAIN: begin
        if (buffer_empty && !data_valid_2 && !data_1_en) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state == S_COMM || state == S_WAIT_FULL)
      modulo = (owner == OWN_T) ? MOD_T : MOD_F;

    case (state)
      S_COMM:      state_led = 4'b0010;
      S_WAIT_FULL: state_led = 4'b0100;
      S_DRAIN:     state_led = 4'b1000;
      default:     state_led = 4'b0001;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner     <= OWN_F;
      req_f     <= 1'b0;
      req_t     <= 1'b0;
      burst_cnt <= '0;
      data_1    <= '0;
      data_1_en <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;

      // Stop beats any start in the same cycle; starts are ignored while draining.
      if (stop) begin
        req_f <= 1'b0;
        req_t <= 1'b0;
      end else if (state != S_DRAIN) begin
        if (start_f) req_f <= 1'b1;
        if (start_t) req_t <= 1'b1;
      end

      // A fresh grant out of IDLE always starts a full burst.
      if (state == S_IDLE)  burst_cnt <= '0;
      else if (burst_end)   burst_cnt <= '0;
      else if (accept)      burst_cnt <= burst_cnt + 1'b1;

      data_1_en <= accept;
      if (accept) data_1 <= accept_data;
    end
  end

endmodule

// File: tb/tb_prod_arbiter.sv
// Directed self-checking bench for prod_arbiter (BURST=4): grant, rotation,
// full stall, stop/drain and asynchronous reset behaviour.
module tb_prod_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_f = 1'b0, start_t = 1'b0, stop = 1'b0;
  logic          buffer_full = 1'b0, buffer_empty = 1'b1, data_valid_2 = 1'b0;
  logic          f_valid = 1'b0, t_valid = 1'b0;
  logic [DW-1:0] f_out = '0, t_out = '0;
  logic          f_en, t_en, data_1_en;
  logic [DW-1:0] data_1;
  logic [1:0]    modulo;
  logic [3:0]    state_led;

  int n_checks = 0;
  int n_fail   = 0;

  prod_arbiter #(.DW(DW), .BURST(4)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop(stop),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_valid_2(data_valid_2),
    .f_valid(f_valid), .t_valid(t_valid), .f_out(f_out), .t_out(t_out),
    .f_en(f_en), .t_en(t_en), .data_1(data_1), .data_1_en(data_1_en),
    .modulo(modulo), .state_led(state_led)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_to_idle();
    bit reached = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0; buffer_empty = 1'b1; data_valid_2 = 1'b0;
    f_valid = 1'b0; t_valid = 1'b0; buffer_full = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      @(negedge clk);
      if (state_led === 4'b0001) reached = 1'b1;
      step();
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL drain_to_idle state_led=%b required=0001", state_led); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++; if (data_1_en !== 1'b0) begin n_fail++; $display("FAIL reset_data_1_en got=%b exp=0", data_1_en); end
    n_checks++; if (data_1 !== '0)      begin n_fail++; $display("FAIL reset_data_1 got=%h exp=0000", data_1); end
    n_checks++; if (modulo !== 2'd0)    begin n_fail++; $display("FAIL reset_modulo got=%0d exp=0", modulo); end
    n_checks++; if (state_led !== 4'b0001) begin n_fail++; $display("FAIL reset_state_led got=%b exp=0001", state_led); end
    n_checks++; if ({f_en, t_en} !== 2'b00) begin n_fail++; $display("FAIL reset_enables got=%b exp=00", {f_en, t_en}); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_f();
    logic [DW-1:0] vals [4] = '{16'd1, 16'd1, 16'd2, 16'd3};
    start_f = 1'b1; f_valid = 1'b1;
    step();
    start_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_out = vals[i];
      @(negedge clk);
      n_checks++; if (f_en !== 1'b1) begin n_fail++; $display("FAIL single_f_en i=%0d got=%b exp=1", i, f_en); end
      n_checks++; if (modulo !== 2'd1) begin n_fail++; $display("FAIL single_modulo i=%0d got=%0d exp=1", i, modulo); end
      n_checks++; if (data_1_en !== (i > 0)) begin n_fail++; $display("FAIL single_strobe i=%0d got=%b exp=%b", i, data_1_en, (i > 0)); end
      if (i > 0) begin
        n_checks++; if (data_1 !== vals[i-1]) begin n_fail++; $display("FAIL single_data i=%0d got=%0d exp=%0d", i, data_1, vals[i-1]); end
      end
      step();
    end
    f_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (data_1_en !== 1'b1 || data_1 !== 16'd3) begin n_fail++; $display("FAIL single_last got=%b/%0d exp=1/3", data_1_en, data_1); end
    step();
    @(negedge clk);
    n_checks++; if (data_1_en !== 1'b0) begin n_fail++; $display("FAIL single_no_strobe got=%b exp=0", data_1_en); end
    step();
    drain_to_idle();
  endtask

  task automatic test_round_robin();
    logic          own, prev_own;
    logic [DW-1:0] exp_word;
    start_f = 1'b1; start_t = 1'b1; f_valid = 1'b1; t_valid = 1'b1;
    step();
    start_f = 1'b0; start_t = 1'b0;
    prev_own = 1'b0;
    for (int c = 0; c < 12; c++) begin
      own   = ((c / 4) % 2) == 1;
      f_out = 16'hF000 | 16'(c);
      t_out = 16'hA000 | 16'(c);
      @(negedge clk);
      n_checks++; if ({f_en, t_en} !== {!own, own}) begin n_fail++; $display("FAIL rr_enables c=%0d got=%b exp=%b", c, {f_en, t_en}, {!own, own}); end
      n_checks++; if (modulo !== (own ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL rr_modulo c=%0d got=%0d exp=%0d", c, modulo, own ? 2 : 1); end
      if (c > 0) begin
        exp_word = (prev_own ? 16'hA000 : 16'hF000) | 16'(c - 1);
        n_checks++; if (data_1_en !== 1'b1 || data_1 !== exp_word) begin n_fail++; $display("FAIL rr_data c=%0d got=%b/%h exp=1/%h", c, data_1_en, data_1, exp_word); end
      end
      prev_own = own;
      step();
    end
    // Stop: enables drop at once, but the word accepted last cycle is still written.
    stop = 1'b1;
    @(negedge clk);
    n_checks++; if ({f_en, t_en} !== 2'b00) begin n_fail++; $display("FAIL rr_stop_enables got=%b exp=00", {f_en, t_en}); end
    n_checks++; if (data_1_en !== 1'b1 || data_1 !== 16'hF00B) begin n_fail++; $display("FAIL rr_stop_inflight got=%b/%h exp=1/f00b", data_1_en, data_1); end
    step();
    stop = 1'b0;
    drain_to_idle();
  endtask

  task automatic test_full_stall();
    logic          fen_exp, ten_exp, prev_acc;
    logic [3:0]    led_exp;
    logic [DW-1:0] prev_data;
    start_f = 1'b1; start_t = 1'b1; f_valid = 1'b1; t_valid = 1'b1;
    step();
    start_f = 1'b0; start_t = 1'b0;
    prev_acc = 1'b0; prev_data = '0;
    for (int c = 0; c < 12; c++) begin
      buffer_full = (c >= 2 && c <= 6);
      f_out = 16'h0100 + 16'(c);
      t_out = 16'h0200 + 16'(c);
      fen_exp = (c == 0 || c == 1 || c == 8 || c == 9);
      ten_exp = (c >= 10);
      led_exp = (c >= 3 && c <= 7) ? 4'b0100 : 4'b0010;
      @(negedge clk);
      n_checks++; if ({f_en, t_en} !== {fen_exp, ten_exp}) begin n_fail++; $display("FAIL full_enables c=%0d got=%b exp=%b", c, {f_en, t_en}, {fen_exp, ten_exp}); end
      n_checks++; if (state_led !== led_exp) begin n_fail++; $display("FAIL full_state c=%0d got=%b exp=%b", c, state_led, led_exp); end
      n_checks++; if (data_1_en !== prev_acc) begin n_fail++; $display("FAIL full_strobe c=%0d got=%b exp=%b", c, data_1_en, prev_acc); end
      if (prev_acc) begin
        n_checks++; if (data_1 !== prev_data) begin n_fail++; $display("FAIL full_data c=%0d got=%h exp=%h", c, data_1, prev_data); end
      end
      if (c >= 3 && c <= 7) begin
        n_checks++; if (modulo !== 2'd1) begin n_fail++; $display("FAIL full_modulo c=%0d got=%0d exp=1", c, modulo); end
      end
      prev_acc  = fen_exp | ten_exp;
      prev_data = fen_exp ? f_out : t_out;
      step();
    end
    drain_to_idle();
  endtask

  task automatic test_stop_drain();
    start_f = 1'b1; f_valid = 1'b1; f_out = 16'h0042;
    step();
    start_f = 1'b0;
    step();
    stop = 1'b1; start_t = 1'b1;
    @(negedge clk);
    n_checks++; if (f_en !== 1'b0) begin n_fail++; $display("FAIL stop_f_en got=%b exp=0", f_en); end
    n_checks++; if (data_1_en !== 1'b1 || data_1 !== 16'h0042) begin n_fail++; $display("FAIL stop_inflight got=%b/%h exp=1/0042", data_1_en, data_1); end
    step();
    stop = 1'b0; start_t = 1'b0; f_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (state_led !== 4'b1000 || modulo !== 2'd0) begin n_fail++; $display("FAIL stop_drain got=%b/%0d exp=1000/0", state_led, modulo); end
    n_checks++; if (data_1_en !== 1'b0) begin n_fail++; $display("FAIL stop_no_strobe got=%b exp=0", data_1_en); end
    step();
    @(negedge clk);
    n_checks++; if (state_led !== 4'b0001) begin n_fail++; $display("FAIL stop_idle got=%b exp=0001", state_led); end
    step();
    @(negedge clk);
    n_checks++; if (state_led !== 4'b0001 || t_en !== 1'b0) begin n_fail++; $display("FAIL stop_t_not_requested got=%b/%b exp=0001/0", state_led, t_en); end
    step();
  endtask

  task automatic test_drain_hold();
    start_f = 1'b1;
    step();
    start_f = 1'b0; stop = 1'b1; buffer_empty = 1'b0;
    step();
    stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      start_f = (k % 2) == 0;
      start_t = (k % 2) == 1;
      @(negedge clk);
      n_checks++; if (state_led !== 4'b1000) begin n_fail++; $display("FAIL hold_state k=%0d got=%b exp=1000", k, state_led); end
      n_checks++; if ({f_en, t_en} !== 2'b00) begin n_fail++; $display("FAIL hold_enables k=%0d got=%b exp=00", k, {f_en, t_en}); end
      step();
    end
    start_f = 1'b0; start_t = 1'b0; buffer_empty = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (state_led !== 4'b0001) begin n_fail++; $display("FAIL hold_exit got=%b exp=0001", state_led); end
    step();
    @(negedge clk);
    n_checks++; if (state_led !== 4'b0001) begin n_fail++; $display("FAIL hold_starts_ignored got=%b exp=0001", state_led); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    start_f = 1'b1; f_valid = 1'b1; f_out = 16'h5555;
    step();
    start_f = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (data_1_en !== 1'b0 || data_1 !== '0) begin n_fail++; $display("FAIL rst_mid_data got=%b/%h exp=0/0000", data_1_en, data_1); end
    n_checks++; if (state_led !== 4'b0001 || modulo !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got=%b/%0d exp=0001/0", state_led, modulo); end
    n_checks++; if ({f_en, t_en} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_enables got=%b exp=00", {f_en, t_en}); end
    f_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    start_t = 1'b1; t_valid = 1'b1; t_out = 16'h0777;
    step();
    start_t = 1'b0;
    @(negedge clk);
    n_checks++; if (modulo !== 2'd2) begin n_fail++; $display("FAIL rst_after_modulo got=%0d exp=2", modulo); end
    n_checks++; if ({f_en, t_en} !== 2'b01) begin n_fail++; $display("FAIL rst_after_enables got=%b exp=01", {f_en, t_en}); end
    step();
    t_valid = 1'b0;
    drain_to_idle();
  endtask

  initial begin
    test_reset();
    test_single_f();
    test_round_robin();
    test_full_stall();
    test_stop_drain();
    test_drain_hold();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
